pe_accum: RTL and testbench
===========================

PE_ACCUM -- requirements
Module: pe_accum

Interface
REQ-001 Parameter WORDSIZE, default 16: width of the incoming product word, signed two's complement.
REQ-002 Parameter ACCW, default 24: width of the accumulator and result word, signed; ACCW SHALL be at least WORDSIZE+1.
REQ-003 iclk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 irst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 idata  input  WORDSIZE: product term from the upstream PE.
REQ-006 ivalid  input  1: idata is a valid term this cycle; there is no upstream backpressure.
REQ-007 ilast  input  1: qualified by ivalid; marks the final term of a group (one output neuron).
REQ-008 odata  output  ACCW: accumulated group result at the head of the output buffer.
REQ-009 ovalid  output  1: odata is valid.
REQ-010 iready  input  1: downstream accepts; a transfer occurs when ovalid and iready are both high.
REQ-011 osat  output  1: the head result saturated during accumulation.
REQ-012 oovf  output  1: sticky; at least one completed result was dropped because the buffer was full.

Function
REQ-013 Every beat with ivalid=1 SHALL be accepted; ilast with ivalid=0 SHALL be ignored.
REQ-014 FSM states: IDLE (no partial sum) and ACCUM (partial sum held); reset state is IDLE.
REQ-015 IDLE, ivalid=1 and ilast=0 -> ACCUM, with acc = sign-extended idata and sat = 0.
REQ-016 ACCUM, ivalid=1 and ilast=0 -> ACCUM, with acc = sat_add(acc, idata) and sat |= the saturation event.
REQ-017 ivalid=1 and ilast=1 in any state -> IDLE, and the group result is pushed: IDLE uses sign-extended idata; ACCUM uses sat_add(acc, idata).
REQ-018 sat_add SHALL clamp to +(2^(ACCW-1)-1) or -2^(ACCW-1) on signed overflow; an intermediate clamp SHALL persist, and later terms SHALL add to the clamped value.
REQ-019 The pushed entry SHALL carry {result, sat}; osat SHALL reflect the head entry's sat.
REQ-020 Output buffer: 2-entry FIFO; odata, osat and ovalid SHALL come directly from registers.
REQ-021 Latency: with the FIFO empty, ovalid SHALL rise in the cycle after the edge that samples the ilast beat.
REQ-022 The FIFO SHALL pop on ovalid&iready; the head SHALL hold stable while ovalid=1 and iready=0.
REQ-023 Push and pop in the same cycle SHALL both take effect at any occupancy, including full.
REQ-024 Push while full without a same-cycle pop SHALL drop the new result, keep the FIFO unchanged, and set oovf.
REQ-025 oovf SHALL clear only on reset.
REQ-026 Order SHALL be preserved, and no result SHALL be duplicated.

Reset
REQ-027 irst_n=0 SHALL immediately force: FSM to IDLE, acc=0, FIFO empty, ovalid=0, odata=0, osat=0, oovf=0.
REQ-028 Reset asserted mid-group SHALL discard the partial sum; the first valid beat after release SHALL start a new group.
REQ-029 Deassertion is synchronised externally; no input beat is presented in the first cycle after release.

Verification
REQ-030 Basic group: beats 5, -2, 7 (ilast on 7), iready=1 -> one cycle later odata=10, ovalid=1 for one cycle, osat=0.
REQ-031 Single-beat group: idata=0xFFFF with ivalid=ilast=1 -> odata=0xFFFFFF (-1), osat=0.
REQ-032 Saturation: 300 beats of 0x7FFF, last one tagged -> odata=0x7FFFFF (8388607), osat=1; the next group 1, 1 -> odata=2, osat=0.
REQ-033 Backpressure: iready=0, three single-beat groups 1, 2, 3 -> ovalid=1 with odata=1 held; oovf=1 after the third. Then iready=1 -> outputs 1 then 2 on consecutive cycles, then ovalid=0; oovf stays 1.
REQ-034 Full with simultaneous pop: FIFO holds {1, 2}; iready=1 in the same cycle group 3 completes -> output sequence 1, 2, 3, and oovf=0.
REQ-035 Reset mid-group: beats 100, 200, then irst_n pulsed low, then a group 4, 6 -> odata=10 only, with no stale result.

Source files
------------

// File: rtl/pe_accum_if.sv
// ---------------------------------------------------------------------------
// pe_accum_if
// Bundles the product-term input stream and the result output stream of
// pe_accum.
//
// Handshake semantics:
//   input side  - every cycle with ivalid=1 carries one term in idata; ilast
//                 marks the final term of a group and is ignored when
//                 ivalid=0. There is no backpressure toward the producer.
//   output side - odata/osat describe the head result whenever ovalid=1; a
//                 transfer happens on a rising clock edge where ovalid and
//                 iready are both 1. While ovalid=1 and iready=0 the head is
//                 held stable. oovf is a sticky drop flag.
//
// Modports:
//   master - the environment: drives the term stream and iready
//   slave  - pe_accum itself
// ---------------------------------------------------------------------------
interface pe_accum_if #(
   parameter int WORDSIZE = 16,
   parameter int ACCW     = 24
);
   logic [WORDSIZE-1:0] idata;
   logic                ivalid;
   logic                ilast;
   logic [ACCW-1:0]     odata;
   logic                ovalid;
   logic                iready;
   logic                osat;
   logic                oovf;

   modport master (
      output idata, ivalid, ilast, iready,
      input  odata, ovalid, osat, oovf
   );

   modport slave (
      input  idata, ivalid, ilast, iready,
      output odata, ovalid, osat, oovf
   );
endinterface

// File: rtl/pe_accum.sv
// ---------------------------------------------------------------------------
// pe_accum
// Accumulates signed product terms from an upstream PE into one saturating
// sum per group (one output neuron) and queues finished results in a
// 2-entry output buffer.
//
// Ports:
//   iclk       - clock, all state updates on the rising edge
//   irst_n     - asynchronous active-low reset
//   bus        - pe_accum_if.slave: idata/ivalid/ilast term stream in,
//                odata/ovalid/osat/oovf result stream out, iready in
//   odbg_state - accumulator FSM state (0 = IDLE, 1 = ACCUM)
//
// Parameters:
//   WORDSIZE   - width of the signed product term
//   ACCW       - width of the signed accumulator/result; must be at least
//                WORDSIZE+1 so the first term of a group can never overflow
// ---------------------------------------------------------------------------
module pe_accum #(
   parameter int WORDSIZE = 16,
   parameter int ACCW     = 24
) (
   input  logic          iclk,
   input  logic          irst_n,
   pe_accum_if.slave     bus,
   output logic          odbg_state
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ACCUM = 1'b1
   } state_t;

   localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
   localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

   // accumulator state
   state_t          state_q, state_d;
   logic [ACCW-1:0] acc_q, acc_d;
   logic            sat_q, sat_d;

   // saturating adder
   logic [ACCW-1:0] term;
   logic [ACCW:0]   sum_wide;
   logic            sum_ovf;
   logic [ACCW-1:0] sum_sat;

   // completed result handed to the output buffer
   logic            push;
   logic [ACCW-1:0] push_data;
   logic            push_sat;

   // output buffer: head entry drives the outputs, tail is the second slot
   logic [ACCW-1:0] head_data_q, head_data_d;
   logic            head_sat_q, head_sat_d;
   logic [ACCW-1:0] tail_data_q, tail_data_d;
   logic            tail_sat_q, tail_sat_d;
   logic            ovalid_q, ovalid_d;
   logic            full_q, full_d;
   logic            oovf_q, oovf_d;
   logic            pop;

   // ------------------------------------------------------------------------
   // Saturating add of the sign-extended term to the running sum. Overflow is
   // detected from one guard bit: the sum overflowed when the guard bit and
   // the result sign bit disagree, and the guard bit gives the direction.
   // ------------------------------------------------------------------------
   always_comb begin
      term     = {{(ACCW-WORDSIZE){bus.idata[WORDSIZE-1]}}, bus.idata};
      sum_wide = {acc_q[ACCW-1], acc_q} + {term[ACCW-1], term};
      sum_ovf  = sum_wide[ACCW] ^ sum_wide[ACCW-1];
      if (sum_ovf) begin
         sum_sat = sum_wide[ACCW] ? ACC_MIN : ACC_MAX;
      end else begin
         sum_sat = sum_wide[ACCW-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Accumulator FSM: next state and the push request for a finished group.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sat_d     = sat_q;
      push      = 1'b0;
      push_data = '0;
      push_sat  = 1'b0;

      if (bus.ivalid) begin
         case (state_q)
            S_IDLE: begin
               if (bus.ilast) begin
                  // single-term group: the term itself is the result
                  push      = 1'b1;
                  push_data = term;
                  push_sat  = 1'b0;
               end else begin
                  state_d = S_ACCUM;
                  acc_d   = term;
                  sat_d   = 1'b0;
               end
            end
            S_ACCUM: begin
               if (bus.ilast) begin
                  push      = 1'b1;
                  push_data = sum_sat;
                  push_sat  = sat_q | sum_ovf;
                  state_d   = S_IDLE;
                  acc_d     = '0;
                  sat_d     = 1'b0;
               end else begin
                  // a clamped value is kept; later terms add to it
                  acc_d = sum_sat;
                  sat_d = sat_q | sum_ovf;
               end
            end
            default: begin
               state_d = S_IDLE;
               acc_d   = '0;
               sat_d   = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output buffer. Occupancy is encoded by ovalid_q (head used) and full_q
   // (tail used). A push into a full buffer survives only if the head pops
   // in the same cycle; otherwise it is dropped and oovf latches.
   // ------------------------------------------------------------------------
   assign pop = ovalid_q & bus.iready;

   always_comb begin
      head_data_d = head_data_q;
      head_sat_d  = head_sat_q;
      tail_data_d = tail_data_q;
      tail_sat_d  = tail_sat_q;
      ovalid_d    = ovalid_q;
      full_d      = full_q;
      oovf_d      = oovf_q;

      if (!ovalid_q) begin
         // empty
         if (push) begin
            head_data_d = push_data;
            head_sat_d  = push_sat;
            ovalid_d    = 1'b1;
         end
      end else if (!full_q) begin
         // one entry
         if (push && pop) begin
            head_data_d = push_data;
            head_sat_d  = push_sat;
         end else if (push) begin
            tail_data_d = push_data;
            tail_sat_d  = push_sat;
            full_d      = 1'b1;
         end else if (pop) begin
            ovalid_d = 1'b0;
         end
      end else begin
         // two entries
         if (pop) begin
            head_data_d = tail_data_q;
            head_sat_d  = tail_sat_q;
            if (push) begin
               tail_data_d = push_data;
               tail_sat_d  = push_sat;
            end else begin
               full_d = 1'b0;
            end
         end else if (push) begin
            oovf_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         sat_q       <= 1'b0;
         head_data_q <= '0;
         head_sat_q  <= 1'b0;
         tail_data_q <= '0;
         tail_sat_q  <= 1'b0;
         ovalid_q    <= 1'b0;
         full_q      <= 1'b0;
         oovf_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         sat_q       <= sat_d;
         head_data_q <= head_data_d;
         head_sat_q  <= head_sat_d;
         tail_data_q <= tail_data_d;
         tail_sat_q  <= tail_sat_d;
         ovalid_q    <= ovalid_d;
         full_q      <= full_d;
         oovf_q      <= oovf_d;
      end
   end

   assign bus.odata  = head_data_q;
   assign bus.osat   = head_sat_q;
   assign bus.ovalid = ovalid_q;
   assign bus.oovf   = oovf_q;
   assign odbg_state = (state_q == S_ACCUM);

endmodule

// File: tb/tb_pe_accum.sv
// ---------------------------------------------------------------------------
// tb_pe_accum
// Self-checking bench for pe_accum. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A reference model
// computes each group result when its terms are driven and queues it; the
// output monitor pops and compares on every transfer.
// ---------------------------------------------------------------------------
module tb_pe_accum;

   localparam int     WORDSIZE = 16;
   localparam int     ACCW     = 24;
   localparam longint ACC_MAX  = (longint'(1) <<< (ACCW-1)) - 1;
   localparam longint ACC_MIN  = -(longint'(1) <<< (ACCW-1));

   // ---------------- clock / reset ----------------
   logic iclk   = 1'b0;
   logic irst_n = 1'b0;
   logic odbg_state;

   always #5 iclk = ~iclk;

   pe_accum_if #(.WORDSIZE(WORDSIZE), .ACCW(ACCW)) bus ();

   pe_accum #(.WORDSIZE(WORDSIZE), .ACCW(ACCW)) dut (
      .iclk       (iclk),
      .irst_n     (irst_n),
      .bus        (bus),
      .odbg_state (odbg_state)
   );

   // ---------------- scoreboard state ----------------
   int            n_checks = 0;
   int            n_errors = 0;
   int            n_out    = 0;
   logic [ACCW:0] exp_q[$];        // {sat, data}

   longint        model_acc    = 0;
   bit            model_active = 1'b0;
   bit            model_sat    = 1'b0;
   bit            model_keep   = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference accumulator, applied when a term is driven
   task automatic model_beat(input logic [WORDSIZE-1:0] d, input bit last);
      longint t;
      t = longint'($signed(d));
      if (!model_active) begin
         model_acc = t;
         model_sat = 1'b0;
      end else begin
         model_acc = model_acc + t;
         if (model_acc > ACC_MAX) begin
            model_acc = ACC_MAX;
            model_sat = 1'b1;
         end else if (model_acc < ACC_MIN) begin
            model_acc = ACC_MIN;
            model_sat = 1'b1;
         end
      end
      if (last) begin
         if (model_keep) exp_q.push_back({model_sat, model_acc[ACCW-1:0]});
         model_active = 1'b0;
      end else begin
         model_active = 1'b1;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_beat(input logic [WORDSIZE-1:0] d, input bit last);
      @(posedge iclk);
      #1;
      bus.ivalid = 1'b1;
      bus.idata  = d;
      bus.ilast  = last;
      model_beat(d, last);
   endtask

   // idle cycle; ilast may be noise since it must be ignored without ivalid
   task automatic drive_idle(input bit last_noise);
      @(posedge iclk);
      #1;
      bus.ivalid = 1'b0;
      bus.idata  = WORDSIZE'($urandom);
      bus.ilast  = last_noise;
   endtask

   task automatic set_ready(input bit v);
      @(posedge iclk);
      #1;
      bus.ivalid = 1'b0;
      bus.ilast  = 1'b0;
      bus.iready = v;
   endtask

   task automatic do_reset();
      @(posedge iclk);
      #1;
      irst_n     = 1'b0;
      bus.ivalid = 1'b0;
      bus.ilast  = 1'b0;
      #1;
      check("rst_ovalid", bus.ovalid, 0);
      check("rst_odata",  bus.odata,  0);
      check("rst_osat",   bus.osat,   0);
      check("rst_oovf",   bus.oovf,   0);
      check("rst_state",  odbg_state, 0);
      repeat (2) @(posedge iclk);
      #1;
      irst_n       = 1'b1;
      model_active = 1'b0;
      model_acc    = 0;
      model_sat    = 1'b0;
      exp_q.delete();
      drive_idle(1'b0);
   endtask

   // ---------------- output monitor ----------------
   always @(negedge iclk) begin
      logic [ACCW:0] e;
      if (irst_n && bus.ovalid && bus.iready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_data", bus.odata, e[ACCW-1:0]);
            check("out_sat",  bus.osat,  e[ACCW]);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int n_before;
      int len;

      bus.idata  = '0;
      bus.ivalid = 1'b0;
      bus.ilast  = 1'b0;
      bus.iready = 1'b1;

      do_reset();

      // basic group 5, -2, 7
      drive_beat(16'd5, 1'b0);
      drive_beat(16'hFFFE, 1'b0);
      drive_beat(16'd7, 1'b1);
      drive_idle(1'b0);
      @(negedge iclk);
      check("basic_ovalid", bus.ovalid, 1);
      check("basic_odata",  bus.odata,  24'd10);
      check("basic_osat",   bus.osat,   0);
      @(negedge iclk);
      check("basic_one_cycle", bus.ovalid, 0);

      // single-beat group of -1
      drive_beat(16'hFFFF, 1'b1);
      drive_idle(1'b0);
      @(negedge iclk);
      check("single_odata", bus.odata, 24'hFFFFFF);
      check("single_osat",  bus.osat,  0);

      // random groups with gaps and ilast noise on idle cycles
      for (int g = 0; g < 20; g++) begin
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            drive_beat(WORDSIZE'($urandom), b == len - 1);
            if ($urandom_range(0, 2) == 0) drive_idle(1'($urandom_range(0, 1)));
         end
      end
      drive_idle(1'b0);

      // positive saturation over 300 terms
      for (int i = 0; i < 300; i++) begin
         drive_beat(16'h7FFF, i == 299);
         if (i == 1) begin
            @(negedge iclk);
            check("accum_state", odbg_state, 1);
         end
      end
      drive_idle(1'b0);
      @(negedge iclk);
      check("sat_odata", bus.odata, 24'h7FFFFF);
      check("sat_osat",  bus.osat,  1);
      drive_beat(16'd1, 1'b0);
      drive_beat(16'd1, 1'b1);
      drive_idle(1'b0);
      @(negedge iclk);
      check("post_sat_odata", bus.odata, 24'd2);
      check("post_sat_osat",  bus.osat,  0);

      // backpressure with overflow drop
      set_ready(1'b0);
      drive_beat(16'd1, 1'b1);
      drive_beat(16'd2, 1'b1);
      model_keep = 1'b0;
      drive_beat(16'd3, 1'b1);
      model_keep = 1'b1;
      drive_idle(1'b0);
      @(negedge iclk);
      check("bp_ovalid", bus.ovalid, 1);
      check("bp_odata",  bus.odata,  24'd1);
      check("bp_oovf",   bus.oovf,   1);
      repeat (3) @(negedge iclk);
      check("bp_hold_ovalid", bus.ovalid, 1);
      check("bp_hold_odata",  bus.odata,  24'd1);
      set_ready(1'b1);
      @(negedge iclk);
      check("bp_first",  bus.odata, 24'd1);
      @(negedge iclk);
      check("bp_second", bus.odata, 24'd2);
      @(negedge iclk);
      check("bp_empty",  bus.ovalid, 0);
      check("bp_oovf_sticky", bus.oovf, 1);

      // full buffer with simultaneous pop and push
      do_reset();
      set_ready(1'b0);
      drive_beat(16'd1, 1'b1);
      drive_beat(16'd2, 1'b1);
      n_before = n_out;
      @(posedge iclk);
      #1;
      bus.iready = 1'b1;
      bus.ivalid = 1'b1;
      bus.idata  = 16'd3;
      bus.ilast  = 1'b1;
      model_beat(16'd3, 1'b1);
      drive_idle(1'b0);
      repeat (4) @(negedge iclk);
      check("full_pop_count", n_out - n_before, 3);
      check("full_pop_oovf",  bus.oovf, 0);
      check("full_pop_empty", bus.ovalid, 0);

      // reset in the middle of a group
      drive_beat(16'd100, 1'b0);
      drive_beat(16'd200, 1'b0);
      do_reset();
      check("mid_rst_state", odbg_state, 0);
      drive_beat(16'd4, 1'b0);
      drive_beat(16'd6, 1'b1);
      drive_idle(1'b0);
      @(negedge iclk);
      check("mid_rst_odata", bus.odata, 24'd10);

      // drain
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge iclk);
      end
      repeat (2) @(negedge iclk);
      check("drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
